// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer: job-level controller for the systolic array fetcher.
// Accepts a job, pulses load_params, holds start_comp until the fetcher's
// ready rises, snapshots the ARRAY_W x ARRAY_W result matrix and streams it
// out row-major over a valid/ready handshake.
// Optional feature macro: SEQ_TIMEOUT_EN (COMPUTE timeout with sticky err).
module sys_array_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ARRAY_W     = 5,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          job_valid,
    output logic                                          job_ready,
    output logic                                          arr_load_params,
    output logic                                          arr_start_comp,
    input  logic                                          arr_ready,
    input  logic [ARRAY_W*ARRAY_W*2*DATA_WIDTH-1:0]       arr_result,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [2*DATA_WIDTH-1:0]                       res_data,
    output logic [$clog2(ARRAY_W*ARRAY_W)-1:0]            res_index,
    output logic                                          res_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err
);

    localparam int unsigned N  = ARRAY_W * ARRAY_W;
    localparam int unsigned EW = 2 * DATA_WIDTH;
    localparam int unsigned IW = $clog2(ARRAY_W * ARRAY_W);
    localparam int unsigned LW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_CAPTURE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   load_cnt;
    logic            ready_q;
    logic            low_seen;
    logic [EW-1:0]   snap [N];
    logic [IW-1:0]   k;

    logic            accept_c;
    logic            complete_c;
    logic            beat_c;
    logic            last_k_c;
    logic            tmo_hit_c;

    assign accept_c   = job_valid && job_ready;
    // A level already high on entry must be seen low before an edge counts.
    assign complete_c = (state == S_COMPUTE) && arr_ready && !ready_q && low_seen;
    assign beat_c     = res_valid && res_ready;
    assign last_k_c   = (k == IW'(N - 1));

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit_c = (state == S_COMPUTE) && (tmo_cnt == TW'(TIMEOUT - 1));

    // COMPUTE cycle counter, cleared whenever not computing.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == S_COMPUTE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted job.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept_c) begin
            err_q <= 1'b0;
        end else if (tmo_hit_c && !complete_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit_c = 1'b0;
    assign err       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept_c) state_nxt = S_LOAD;
            S_LOAD:    if (load_cnt == LW'(LOAD_CYCLES - 1)) state_nxt = S_COMPUTE;
            S_COMPUTE: begin
                if (complete_c) begin
                    state_nxt = S_CAPTURE;
                end else if (tmo_hit_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_CAPTURE: state_nxt = S_STREAM;
            S_STREAM:  if (beat_c && last_k_c) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // LOAD phase length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt <= '0;
        end else if (state == S_LOAD) begin
            load_cnt <= load_cnt + LW'(1);
        end else begin
            load_cnt <= '0;
        end
    end

    // Fetcher ready edge tracking; both flags start clear on COMPUTE entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q  <= 1'b0;
            low_seen <= 1'b0;
        end else if (state == S_COMPUTE) begin
            ready_q <= arr_ready;
            if (!arr_ready) begin
                low_seen <= 1'b1;
            end
        end else begin
            ready_q  <= 1'b0;
            low_seen <= 1'b0;
        end
    end

    // Result snapshot and registered stream payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                snap[i] <= '0;
            end
            k         <= '0;
            res_data  <= '0;
            res_index <= '0;
            res_last  <= 1'b0;
        end else if (state == S_CAPTURE) begin
            for (int unsigned i = 0; i < N; i++) begin
                snap[i] <= arr_result[i*EW +: EW];
            end
            k         <= '0;
            res_data  <= arr_result[0 +: EW];
            res_index <= '0;
            res_last  <= (N == 1);
        end else if ((state == S_STREAM) && beat_c && !last_k_c) begin
            k         <= k + IW'(1);
            res_data  <= snap[k + IW'(1)];
            res_index <= k + IW'(1);
            res_last  <= ((k + IW'(1)) == IW'(N - 1));
        end
    end

    // Registered control outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            job_ready       <= 1'b1;
            busy            <= 1'b0;
            arr_load_params <= 1'b0;
            arr_start_comp  <= 1'b0;
            res_valid       <= 1'b0;
            done            <= 1'b0;
        end else begin
            job_ready       <= (state_nxt == S_IDLE);
            busy            <= (state_nxt != S_IDLE);
            arr_load_params <= (state_nxt == S_LOAD);
            arr_start_comp  <= (state_nxt == S_COMPUTE);
            res_valid       <= (state_nxt == S_STREAM);
            done            <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: doc/sys_array_sequencer.md
Name: sys_array_sequencer

Overview:
- Job-level controller for the systolic array fetcher.
- Accepts one job per handshake, pulses load_params, holds start_comp until the fetcher reports ready, then snapshots the ARRAY_W x ARRAY_W result matrix.
- Streams the results out one element per handshake, row-major.
- Replaces the free-running counter/shift-register readout with a back-pressured stream for a host-side consumer.

Parameters:
- DATA_WIDTH, 8, operand width; each result element is 2*DATA_WIDTH bits.
- ARRAY_W, 5, array side length; N = ARRAY_W*ARRAY_W result elements.
- LOAD_CYCLES, 2, cycles arr_load_params stays high (1..15).
- TIMEOUT, 1024, maximum COMPUTE cycles; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; single clock domain, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  host requests a job.
- job_ready  out  1  high only in IDLE; job accepted when job_valid && job_ready.
- arr_load_params  out  1  to fetcher load_params.
- arr_start_comp  out  1  to fetcher start_comp.
- arr_ready  in  1  fetcher ready.
- arr_result  in  N*2*DATA_WIDTH  fetcher outputs, flattened; element k = row*ARRAY_W+col at bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH].
- res_valid  out  1  stream valid.
- res_ready  in  1  stream ready.
- res_data  out  2*DATA_WIDTH  current element.
- res_index  out  $clog2(N)  index k of res_data.
- res_last  out  1  high with the element at k = N-1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: all outputs 0 except job_ready = 1. State = IDLE; counters and snapshot cleared. Reset mid-job aborts immediately, with no done pulse.
- IDLE: on job accept, go to LOAD and clear err.
- LOAD: arr_load_params = 1 for exactly LOAD_CYCLES cycles, starting the cycle after accept; then go to COMPUTE.
- COMPUTE:
  - arr_start_comp = 1.
  - arr_ready is registered each cycle (ready_q; forced to 0 on entry to COMPUTE).
  - Completion = arr_ready && !ready_q, a rising edge. A level that is already high at entry counts only after it is seen low.
  - On completion, go to CAPTURE.
- CAPTURE: one cycle. arr_start_comp = 0; snapshot <= arr_result; k <= 0; then go to STREAM.
- Latency: res_valid is first high 2 cycles after the cycle in which the arr_ready edge is sampled.
- STREAM:
  - res_valid = 1; res_data = snapshot[k]; res_index = k; res_last = (k == N-1).
  - On res_valid && res_ready: if k == N-1, go to DONE; else k+1.
  - While res_ready = 0, data, index and last hold stable.
  - Snapshot is unaffected by later arr_result changes.
- DONE: done = 1 for one cycle, then go to IDLE.
- job_valid outside IDLE is ignored; there is no queuing.
- All outputs are registered. res_data comes from the snapshot, never from arr_result combinationally.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in COMPUTE.
  - If it reaches TIMEOUT with no completion: err <= 1, arr_start_comp drops next cycle, state goes to DONE (done pulse), STREAM is skipped.
  - err stays high until the next job accept or reset.
- Undefined: COMPUTE waits indefinitely; err is tied 0; no counter logic is present.

Test Plan:
- Defaults. Reset held 3 cycles, then job_valid 1 cycle -> arr_load_params high exactly 2 cycles starting 1 cycle after accept; then arr_start_comp high; job_ready 0; busy 1.
- Model raises arr_ready 7 cycles into COMPUTE, arr_result element k = k+0x100 -> res_valid first high 2 cycles after the edge; with res_ready=1, 25 consecutive beats: data 0x100..0x118, index 0..24, res_last only on beat 24; done pulses 1 cycle later; job_ready returns 1.
- res_ready toggled 1010... and held 0 for 5 cycles mid-stream; arr_result changed after CAPTURE -> data and index stable while stalled; output equals the original snapshot; no element lost or repeated.
- arr_ready already 1 when COMPUTE is entered, drops after 3 cycles, rises 4 cycles later -> completion only on the later rising edge.
- Reset asserted at stream beat 10 -> next cycle all outputs 0, job_ready 1, no done pulse; a new job then runs cleanly from index 0.
- With SEQ_TIMEOUT_EN and TIMEOUT=16, arr_ready held 0 -> err 1 and done pulse after 16 COMPUTE cycles, no res_valid; next job accept clears err.
